// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display capture block: active-low segment
// patterns (dp excluded), digit strobe codes and the frame FSM state type.
package seg7_pkg;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] Seg0     = 7'h40;
    localparam logic [6:0] Seg1     = 7'h79;
    localparam logic [6:0] Seg2     = 7'h24;
    localparam logic [6:0] Seg3     = 7'h30;
    localparam logic [6:0] Seg4     = 7'h19;
    localparam logic [6:0] Seg5     = 7'h12;
    localparam logic [6:0] Seg6     = 7'h02;
    localparam logic [6:0] Seg7     = 7'h78;
    localparam logic [6:0] Seg8     = 7'h00;
    localparam logic [6:0] Seg9     = 7'h10;
    localparam logic [6:0] SegBlank = 7'h7F;

    localparam logic [2:0] DigitUnits    = 3'b110;
    localparam logic [2:0] DigitTens     = 3'b101;
    localparam logic [2:0] DigitHundreds = 3'b011;

    typedef enum logic [1:0] {
        StWaitU,
        StWaitT,
        StWaitH,
        StConvert
    } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decoder from an observed active-low segment pattern to a BCD
// digit, with flags for a legal 0..9 pattern and for an all-off (blank) pattern.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [7:0] seg_i,
    output logic [3:0] bcd_o,
    output logic       is_valid_o,
    output logic       is_blank_o
);

    // Decimal point carries no digit information.
    logic unused_dp;
    assign unused_dp = seg_i[7];

    always_comb begin
        bcd_o      = 4'd0;
        is_valid_o = 1'b1;
        case (seg_i[6:0])
            Seg0:    bcd_o = 4'd0;
            Seg1:    bcd_o = 4'd1;
            Seg2:    bcd_o = 4'd2;
            Seg3:    bcd_o = 4'd3;
            Seg4:    bcd_o = 4'd4;
            Seg5:    bcd_o = 4'd5;
            Seg6:    bcd_o = 4'd6;
            Seg7:    bcd_o = 4'd7;
            Seg8:    bcd_o = 4'd8;
            Seg9:    bcd_o = 4'd9;
            default: is_valid_o = 1'b0;
        endcase
    end

    assign is_blank_o = (seg_i[6:0] == SegBlank);

endmodule

// File: rtl/seg7_capture.sv
// Captures a 3-digit multiplexed 7-segment display into binary and BCD.
// Define SEG7_CAPTURE_BLANK_EN to accept blank leading digits as zero.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  seg_i,
    input  logic [2:0]  digit_i,
    output logic [9:0]  number_o,
    output logic [11:0] digits_bcd_o,
    output logic        valid_o,
    output logic        frame_err_o
);

`ifdef SEG7_CAPTURE_BLANK_EN
    localparam bit BlankEn = 1'b1;
`else
    localparam bit BlankEn = 1'b0;
`endif

    localparam logic [15:0] LatchCount = 16'(STABLE_CYCLES - 1);

    // {seg, digit} through two sync flops, plus one more stage for change detection
    logic [10:0] sync1_q, sync2_q, prev_q;
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {seg_i, digit_i};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (sync2_q != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    logic [7:0] lat_seg;
    logic [2:0] lat_digit;
    logic       latch_evt;
    logic       is_u, is_t, is_h;

    assign lat_seg   = prev_q[10:3];
    assign lat_digit = prev_q[2:0];
    assign is_u      = (lat_digit == DigitUnits);
    assign is_t      = (lat_digit == DigitTens);
    assign is_h      = (lat_digit == DigitHundreds);
    assign latch_evt = (cnt_q == LatchCount) && (is_u || is_t || is_h);

    logic [3:0] dec_bcd;
    logic       dec_valid, dec_blank;

    seg7_pattern_decode u_decode (
        .seg_i      (lat_seg),
        .bcd_o      (dec_bcd),
        .is_valid_o (dec_valid),
        .is_blank_o (dec_blank)
    );

    logic tens_blank_q;
    logic units_ok, tens_ok, hund_ok;

    // A blank tens is only consistent if the hundreds turns out blank as well.
    assign units_ok = latch_evt && is_u && dec_valid;
    assign tens_ok  = latch_evt && is_t && (dec_valid || (BlankEn && dec_blank));
    assign hund_ok  = latch_evt && is_h &&
                      ((dec_valid && !tens_blank_q) || (BlankEn && dec_blank));

    state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StWaitU;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitU: begin
                if (units_ok) state_d = StWaitT;
            end
            StWaitT: begin
                if (tens_ok)        state_d = StWaitH;
                else if (latch_evt) state_d = units_ok ? StWaitT : StWaitU;
            end
            StWaitH: begin
                if (hund_ok)        state_d = StConvert;
                else if (latch_evt) state_d = units_ok ? StWaitT : StWaitU;
            end
            StConvert: state_d = StWaitU;
            default:   state_d = StWaitU;
        endcase
    end

    logic store_u, store_t, store_h, frame_err_d, do_convert;

    always_comb begin
        store_u     = 1'b0;
        store_t     = 1'b0;
        store_h     = 1'b0;
        frame_err_d = 1'b0;
        do_convert  = 1'b0;
        unique case (state_q)
            StWaitU: store_u = units_ok;
            StWaitT: begin
                store_t = tens_ok;
                if (latch_evt && !tens_ok) begin
                    frame_err_d = 1'b1;
                    store_u     = units_ok;
                end
            end
            StWaitH: begin
                store_h = hund_ok;
                if (latch_evt && !hund_ok) begin
                    frame_err_d = 1'b1;
                    store_u     = units_ok;
                end
            end
            StConvert: do_convert = 1'b1;
            default:   ;
        endcase
    end

    logic [3:0] u_q, t_q, h_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            u_q          <= '0;
            t_q          <= '0;
            h_q          <= '0;
            tens_blank_q <= 1'b0;
        end else begin
            if (store_u) begin
                u_q          <= dec_bcd;
                t_q          <= '0;
                h_q          <= '0;
                tens_blank_q <= 1'b0;
            end else if (frame_err_d) begin
                u_q          <= '0;
                t_q          <= '0;
                h_q          <= '0;
                tens_blank_q <= 1'b0;
            end
            if (store_t) begin
                t_q          <= dec_bcd;
                tens_blank_q <= BlankEn && dec_blank;
            end
            if (store_h) begin
                h_q <= dec_bcd;
            end
        end
    end

    logic [9:0] sum;
    assign sum = 10'(h_q) * 10'd100 + 10'(t_q) * 10'd10 + 10'(u_q);

    logic [9:0]  number_q;
    logic [11:0] bcd_q;
    logic        valid_q, frame_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            number_q    <= '0;
            bcd_q       <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= do_convert;
            frame_err_q <= frame_err_d;
            if (do_convert) begin
                number_q <= sum;
                bcd_q    <= {h_q, t_q, u_q};
            end
        end
    end

    assign number_o     = number_q;
    assign digits_bcd_o = bcd_q;
    assign valid_o      = valid_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture with a short stability window.
module tb_seg7_capture;

    localparam int unsigned StableCycles = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  seg_i;
    logic [2:0]  digit_i;
    logic [9:0]  number_o;
    logic [11:0] digits_bcd_o;
    logic        valid_o;
    logic        frame_err_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int err_cnt      = 0;

    logic [21:0] exp_q[$];
    logic [21:0] obs_q[$];

    // Active-low {dp,g,f,e,d,c,b,a}, dp off
    logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk_i = ~clk_i;

    seg7_capture #(
        .STABLE_CYCLES (StableCycles)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .seg_i        (seg_i),
        .digit_i      (digit_i),
        .number_o     (number_o),
        .digits_bcd_o (digits_bcd_o),
        .valid_o      (valid_o),
        .frame_err_o  (frame_err_o)
    );

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (valid_o) obs_q.push_back({number_o, digits_bcd_o});
            if (frame_err_o) err_cnt++;
        end
    end

    task automatic drive(input logic [7:0] s, input logic [2:0] d, input int cycles);
        seg_i   = s;
        digit_i = d;
        repeat (cycles) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input int h, input int t, input int u);
        drive(seg_lut[u], 3'b110, 10);
        drive(seg_lut[t], 3'b101, 10);
        drive(seg_lut[h], 3'b011, 10);
    endtask

    task automatic idle();
        drive(8'hFF, 3'b111, 12);
    endtask

    task automatic push_exp(input int h, input int t, input int u);
        int n;
        n = h * 100 + t * 10 + u;
        exp_q.push_back({10'(n), 4'(h), 4'(t), 4'(u)});
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        drive(8'hFF, 3'b111, 3);
        tests_run++;
        if (number_o !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_number: got %0d want 0", number_o);
        end
        tests_run++;
        if (digits_bcd_o !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_bcd: got %h want 000", digits_bcd_o);
        end
        tests_run++;
        if (valid_o !== 1'b0 || frame_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pulses: got valid=%b err=%b want 0 0", valid_o, frame_err_o);
        end
        rst_ni = 1'b1;
        idle();
    endtask

    task automatic test_frame_123();
        int err0;
        logic [21:0] e, o;
        err0 = err_cnt;
        push_exp(1, 2, 3);
        send_frame(1, 2, 3);
        idle();
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL f123_count: got %0d pulses want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL f123_value: got %0d/%h want %0d/%h", o[21:12], o[11:0], e[21:12], e[11:0]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        tests_run++;
        if (err_cnt - err0 !== 0) begin
            tests_failed++;
            $display("FAIL f123_err: got %0d frame errors want 0", err_cnt - err0);
        end
    endtask

    task automatic test_skip_tens();
        int err0;
        err0 = err_cnt;
        drive(seg_lut[5], 3'b110, 10);
        drive(seg_lut[4], 3'b011, 10);
        idle();
        tests_run++;
        if (err_cnt - err0 !== 1) begin
            tests_failed++;
            $display("FAIL skip_err: got %0d frame errors want 1", err_cnt - err0);
        end
        tests_run++;
        if (obs_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL skip_valid: got %0d pulses want 0", obs_q.size());
        end
        obs_q.delete();
        tests_run++;
        if (number_o !== 10'd123 || digits_bcd_o !== 12'h123) begin
            tests_failed++;
            $display("FAIL skip_hold: got %0d/%h want 123/123", number_o, digits_bcd_o);
        end
    endtask

    task automatic test_back_to_back();
        int err0;
        logic [21:0] e, o;
        err0 = err_cnt;
        push_exp(9, 9, 9);
        push_exp(0, 0, 0);
        send_frame(9, 9, 9);
        send_frame(0, 0, 0);
        idle();
        tests_run++;
        if (obs_q.size() !== 2) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d pulses want 2", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL b2b_value: got %0d/%h want %0d/%h", o[21:12], o[11:0], e[21:12], e[11:0]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        tests_run++;
        if (err_cnt - err0 !== 0) begin
            tests_failed++;
            $display("FAIL b2b_err: got %0d frame errors want 0", err_cnt - err0);
        end
    endtask

    task automatic test_bad_pattern();
        int err0;
        logic [21:0] e, o;
        err0 = err_cnt;
        // all segments plus dp lit decodes as 8
        push_exp(2, 8, 1);
        drive(seg_lut[1], 3'b110, 10);
        drive(8'h00, 3'b101, 10);
        drive(seg_lut[2], 3'b011, 10);
        // illegal tens pattern aborts; the lone hundreds after it is ignored
        drive(seg_lut[4], 3'b110, 10);
        drive(8'hAA, 3'b101, 10);
        drive(seg_lut[3], 3'b011, 10);
        push_exp(8, 7, 6);
        send_frame(8, 7, 6);
        idle();
        tests_run++;
        if (obs_q.size() !== 2) begin
            tests_failed++;
            $display("FAIL badpat_count: got %0d pulses want 2", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL badpat_value: got %0d/%h want %0d/%h", o[21:12], o[11:0], e[21:12], e[11:0]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        tests_run++;
        if (err_cnt - err0 !== 1) begin
            tests_failed++;
            $display("FAIL badpat_err: got %0d frame errors want 1", err_cnt - err0);
        end
    endtask

    task automatic test_toggle();
        int err0;
        err0 = err_cnt;
        for (int i = 0; i < 15; i++) begin
            drive(seg_lut[i % 2], 3'b110, 2);
        end
        drive(seg_lut[2], 3'b101, 10);
        drive(seg_lut[3], 3'b011, 10);
        idle();
        tests_run++;
        if (obs_q.size() !== 0 || err_cnt - err0 !== 0) begin
            tests_failed++;
            $display("FAIL toggle: got %0d pulses %0d errors want 0 0", obs_q.size(), err_cnt - err0);
        end
        obs_q.delete();
    endtask

    task automatic test_mid_reset();
        int err0;
        logic [21:0] e, o;
        err0 = err_cnt;
        drive(seg_lut[1], 3'b110, 10);
        drive(seg_lut[2], 3'b101, 10);
        drive(seg_lut[3], 3'b011, 3);
        rst_ni = 1'b0;
        #2;
        tests_run++;
        if (number_o !== 10'd0 || digits_bcd_o !== 12'h000 || valid_o !== 1'b0 ||
            frame_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got %0d/%h v=%b e=%b want 0/000 v=0 e=0",
                     number_o, digits_bcd_o, valid_o, frame_err_o);
        end
        drive(8'hFF, 3'b111, 3);
        rst_ni = 1'b1;
        idle();
        // a stray hundreds after reset must not complete the old frame
        drive(seg_lut[3], 3'b011, 10);
        idle();
        tests_run++;
        if (obs_q.size() !== 0 || err_cnt - err0 !== 0 || number_o !== 10'd0) begin
            tests_failed++;
            $display("FAIL midrst_quiet: got %0d pulses %0d errors number=%0d want 0 0 0",
                     obs_q.size(), err_cnt - err0, number_o);
        end
        obs_q.delete();
        push_exp(6, 5, 4);
        send_frame(6, 5, 4);
        idle();
        tests_run++;
        if (obs_q.size() !== 1) begin
            tests_failed++;
            $display("FAIL midrst_count: got %0d pulses want 1", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL midrst_value: got %0d/%h want %0d/%h", o[21:12], o[11:0], e[21:12], e[11:0]);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_blank();
        int err0;
        int exp_err;
        logic [21:0] e, o;
        err0 = err_cnt;
        drive(seg_lut[7], 3'b110, 10);
        drive(8'hFF, 3'b101, 10);
        drive(8'hFF, 3'b011, 10);
`ifdef SEG7_CAPTURE_BLANK_EN
        push_exp(0, 0, 7);
        // blank tens followed by a real hundreds is inconsistent
        drive(seg_lut[1], 3'b110, 10);
        drive(8'hFF, 3'b101, 10);
        drive(seg_lut[3], 3'b011, 10);
        exp_err = 1;
`else
        exp_err = 1;
`endif
        idle();
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL blank_count: got %0d pulses want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL blank_value: got %0d/%h want %0d/%h", o[21:12], o[11:0], e[21:12], e[11:0]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        tests_run++;
        if (err_cnt - err0 !== exp_err) begin
            tests_failed++;
            $display("FAIL blank_err: got %0d frame errors want %0d", err_cnt - err0, exp_err);
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        seg_i   = 8'hFF;
        digit_i = 3'b111;
        test_reset();
        test_frame_123();
        test_skip_tens();
        test_back_to_back();
        test_bad_pattern();
        test_toggle();
        test_mid_reset();
        test_blank();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter: STABLE_CYCLES, default 1000, number of consecutive identical samples needed to accept a digit; legal range 2..65535.
REQ-002 CLK  input  1  single clock for all logic; rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 SEG  input  8  observed segment lines, active-low, bit order {dp,g,f,e,d,c,b,a}.
REQ-005 DIGIT  input  3  observed digit enables, active-low one-cold: 3'b110 units, 3'b101 tens, 3'b011 hundreds.
REQ-006 number  output  10  last successfully captured value, binary, 0..999.
REQ-007 digits_bcd  output  12  last captured digits {hundreds,tens,units}, 4-bit BCD each.
REQ-008 valid  output  1  one-cycle pulse when number/digits_bcd update.
REQ-009 frame_err  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-010 SEG and DIGIT SHALL each pass through a two-flop synchronizer before any other use.
REQ-011 A 16-bit stability counter SHALL clear when the synchronized {SEG,DIGIT} differs from its previous-cycle value, else increment, saturating.
REQ-012 A latch event SHALL fire exactly once per stable run, on the cycle the counter equals STABLE_CYCLES-1, and only if DIGIT is one of the three legal codes.
REQ-013 DIGIT values 3'b111 or with more than one low bit SHALL produce no latch event and no error.
REQ-014 SEG SHALL decode (dp ignored) to 0..9 using standard patterns; any other pattern is invalid.
REQ-015 FSM states: WAIT_U, WAIT_T, WAIT_H, CONVERT; reset state WAIT_U.
REQ-016 WAIT_U: latch event on units with valid pattern stores units, goes to WAIT_T; any other latch event stays in WAIT_U, no error.
REQ-017 WAIT_T/WAIT_H: latch event on expected digit with valid pattern stores it and advances (WAIT_H -> CONVERT).
REQ-018 WAIT_T/WAIT_H: latch event on wrong digit or invalid pattern SHALL pulse frame_err, discard stored digits and go to WAIT_U; if that event was a valid units latch it SHALL be stored and the FSM goes to WAIT_T.
REQ-019 CONVERT SHALL last one cycle, compute h*100 + t*10 + u in 10 bits (no overflow possible) and return to WAIT_U.
REQ-020 number, digits_bcd and valid SHALL be registered on the edge leaving CONVERT: valid is high exactly 2 cycles after the hundreds latch edge.
REQ-021 number and digits_bcd SHALL hold between valid pulses; frame_err SHALL never update them.
REQ-022 Latency from a SEG/DIGIT pin change to its latch event SHALL be 2 + STABLE_CYCLES cycles.

Reset
REQ-023 RST_N low SHALL immediately force: number=0, digits_bcd=0, valid=0, frame_err=0, FSM=WAIT_U, stability counter=0, synchronizers=all ones, stored digits=0.
REQ-024 Reset mid-frame SHALL discard the partial frame without any pulse on frame_err or valid.

Configuration
REQ-025 Macro SEG7_CAPTURE_BLANK_EN defined: blank pattern (SEG=8'hFF, dp ignored) on hundreds is accepted as 0; on tens it is accepted as 0 only if hundreds of the same frame... is not yet known, so blank tens is stored as 0 and flagged, and the frame errors at WAIT_H unless hundreds is also blank.
REQ-026 Macro not defined: blank is an invalid pattern on every digit (REQ-018 applies).

Structure
REQ-027 Package seg7_pkg SHALL hold the ten segment pattern constants, blank constant, three DIGIT strobe constants and the FSM state enum.
REQ-028 Sub-module seg7_pattern_decode SHALL be the combinational SEG -> {bcd[3:0], is_valid, is_blank} decoder; everything else lives in seg7_capture.

Verification (STABLE_CYCLES=4)
REQ-029 Drive units 3, tens 2, hundreds 1, each held 10 cycles -> single valid pulse, number=123, digits_bcd=12'h123.
REQ-030 Drive 9,9,9 -> number=999; then 0,0,0 -> number=0, two valid pulses total.
REQ-031 Units 5 then hundreds 4 (tens skipped) -> one frame_err pulse, no valid, number unchanged.
REQ-032 Tens pattern 8'h00 (all segments on with dp, decodes as 8) accepted; pattern 8'hAA on tens -> frame_err, FSM back to WAIT_U.
REQ-033 Toggle SEG every 2 cycles while DIGIT=units -> no latch event, no pulses; assert RST_N low mid-frame after tens -> all outputs 0, no pulses.
REQ-034 With SEG7_CAPTURE_BLANK_EN: units 7, tens blank, hundreds blank -> number=7; without macro same stimulus -> frame_err.
